intbus_arbiter: RTL and testbench

- Shares the single internal bus master port (18-bit address, 8-bit data, single-cycle strobe, fixed read latency) between NUM_REQ requesters.
- Typical requesters: 6502 external bus interface, SPI/flash loader, debug port.
- Sits between the requesters and the internal address decoder.
- Round-robin arbitration, at most one strobe per clock; read data is routed back to the issuing requester.

---
 rtl/intbus_pkg.sv | 22 ++
 rtl/intbus_arbiter_if.sv | 35 +++
 rtl/intbus_rr_pick.sv | 36 +++
 rtl/intbus_arbiter.sv | 141 ++++++++++++++
 tb/tb_intbus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intbus_pkg.sv
// Shared constants and helpers for the internal bus arbiter slice.
package intbus_pkg;

  localparam int unsigned INTBUS_ADDR_W     = 18;
  localparam int unsigned INTBUS_DATA_W     = 8;
  localparam int unsigned INTBUS_RD_LATENCY = 2;

  localparam int unsigned REQ_EXTBUS = 0;
  localparam int unsigned REQ_SPI    = 1;
  localparam int unsigned REQ_DEBUG  = 2;

  // Index of the set bit in a one-hot vector of up to eight requesters.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/intbus_arbiter_if.sv
// Requester-side and decoder-side signals of the internal bus arbiter.
interface intbus_arbiter_if
  import intbus_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = INTBUS_ADDR_W,
  parameter int unsigned DATA_W  = INTBUS_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wrdata;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic [ADDR_W-1:0]         intbus_addr;
  logic [DATA_W-1:0]         intbus_wrdata;
  logic [DATA_W-1:0]         intbus_rddata;
  logic                      intbus_strobe;
  logic                      intbus_write;

  modport slave (
    input  req_valid, req_addr, req_wrdata, req_write, intbus_rddata,
    output req_ack, rd_valid, rd_data, intbus_addr, intbus_wrdata,
           intbus_strobe, intbus_write
  );

  modport master (
    output req_valid, req_addr, req_wrdata, req_write, intbus_rddata,
    input  req_ack, rd_valid, rd_data, intbus_addr, intbus_wrdata,
           intbus_strobe, intbus_write
  );

endinterface

// File: rtl/intbus_rr_pick.sv
// Combinational round-robin selector: first eligible index above i_ptr, wrapping.
module intbus_rr_pick
  import intbus_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt_oh_c,
  output logic [IDX_W-1:0]   o_gnt_idx_c,
  output logic               o_any_c
);

  logic [NUM_REQ-1:0] w_gnt_oh;
  logic               w_found;
  int unsigned        w_pos;

  always_comb begin
    w_gnt_oh = '0;
    w_found  = 1'b0;
    w_pos    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_pos = (32'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_elig[IDX_W'(w_pos)]) begin
        w_gnt_oh[IDX_W'(w_pos)] = 1'b1;
        w_found                 = 1'b1;
      end
    end
  end

  assign o_gnt_oh_c  = w_gnt_oh;
  assign o_gnt_idx_c = IDX_W'(onehot_to_idx(8'(w_gnt_oh)));
  assign o_any_c     = w_found;

endmodule

// File: rtl/intbus_arbiter.sv
// Round-robin arbiter sharing the internal bus master port among NUM_REQ requesters.
// Build option INTBUS_ARB_PRIO0_EN: requester 0 wins whenever eligible, ptr untouched.
module intbus_arbiter
  import intbus_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_W     = INTBUS_ADDR_W,
  parameter int unsigned DATA_W     = INTBUS_DATA_W,
  parameter int unsigned RD_LATENCY = INTBUS_RD_LATENCY
) (
  input  logic             intbus_clk,
  input  logic             intbus_res_n,
  intbus_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_mask;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_strobe;
  logic               r_write;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wrdata;
  logic [IDX_W-1:0]   r_iss_idx;
  logic [RD_LATENCY-1:0] r_pv;
  logic [IDX_W-1:0]   r_pid [RD_LATENCY];
  logic [NUM_REQ-1:0] r_rd_valid;
  logic [DATA_W-1:0]  r_rd_data;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_rr_oh;
  logic [IDX_W-1:0]   w_rr_idx;
  logic               w_rr_any;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_upd_ptr;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wrdata;
  logic               w_sel_write;

  // Previous grant is masked so a requester still holding valid after its ack is not reissued.
  assign w_elig = bus.req_valid & ~r_mask;

  intbus_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_elig      (w_elig),
    .i_ptr       (r_ptr),
    .o_gnt_oh_c  (w_rr_oh),
    .o_gnt_idx_c (w_rr_idx),
    .o_any_c     (w_rr_any)
  );

  always_comb begin
    w_gnt_oh  = w_rr_oh;
    w_gnt_idx = w_rr_idx;
    w_upd_ptr = 1'b1;
`ifdef INTBUS_ARB_PRIO0_EN
    if (w_elig[0]) begin
      w_gnt_oh  = NUM_REQ'(1);
      w_gnt_idx = '0;
      w_upd_ptr = 1'b0;
    end
`endif
  end

  // Request field mux driven by the one-hot grant.
  always_comb begin
    w_sel_addr   = '0;
    w_sel_wrdata = '0;
    w_sel_write  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_oh[i]) begin
        w_sel_addr   = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wrdata = bus.req_wrdata[i*DATA_W +: DATA_W];
        w_sel_write  = bus.req_write[i];
      end
    end
  end

  always_ff @(posedge intbus_clk or negedge intbus_res_n) begin
    if (!intbus_res_n) begin
      r_ptr     <= IDX_W'(NUM_REQ - 1);
      r_mask    <= '0;
      r_ack     <= '0;
      r_strobe  <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wrdata  <= '0;
      r_iss_idx <= '0;
    end else begin
      r_ack    <= '0;
      r_strobe <= 1'b0;
      r_write  <= 1'b0;
      r_mask   <= '0;
      if (w_rr_any) begin
        r_ack     <= w_gnt_oh;
        r_strobe  <= 1'b1;
        r_write   <= w_sel_write;
        r_addr    <= w_sel_addr;
        r_wrdata  <= w_sel_wrdata;
        r_mask    <= w_gnt_oh;
        r_iss_idx <= w_gnt_idx;
        if (w_upd_ptr) r_ptr <= w_gnt_idx;
      end
    end
  end

  // Read tracking: entry enters behind the strobe so the last stage lines up with intbus_rddata.
  always_ff @(posedge intbus_clk or negedge intbus_res_n) begin
    if (!intbus_res_n) begin
      r_pv       <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) r_pid[i] <= '0;
      r_rd_valid <= '0;
      r_rd_data  <= '0;
    end else begin
      r_pv[0]  <= r_strobe & ~r_write;
      r_pid[0] <= r_iss_idx;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_pid[i] <= r_pid[i-1];
      end
      r_rd_valid <= '0;
      if (r_pv[RD_LATENCY-1]) begin
        r_rd_valid <= NUM_REQ'(1) << r_pid[RD_LATENCY-1];
        r_rd_data  <= bus.intbus_rddata;
      end
    end
  end

  assign bus.req_ack       = r_ack;
  assign bus.rd_valid      = r_rd_valid;
  assign bus.rd_data       = r_rd_data;
  assign bus.intbus_addr   = r_addr;
  assign bus.intbus_wrdata = r_wrdata;
  assign bus.intbus_strobe = r_strobe;
  assign bus.intbus_write  = r_write;

endmodule

// File: tb/tb_intbus_arbiter.sv
// Self-checking bench for intbus_arbiter: directed scenarios plus randomized requesters
// against a transaction-level model with a simple decoder responder.
module tb_intbus_arbiter;
  import intbus_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = INTBUS_ADDR_W;
  localparam int unsigned DW = INTBUS_DATA_W;
  localparam int unsigned L  = INTBUS_RD_LATENCY;

  logic clk   = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  intbus_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  intbus_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L)
  ) dut (
    .intbus_clk   (clk),
    .intbus_res_n (res_n),
    .bus          (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [N-1:0]  drv_valid;
  logic [N-1:0]  drv_wr;
  logic [AW-1:0] drv_addr [N];
  logic [DW-1:0] drv_data [N];
  logic [DW-1:0] mem [logic [AW-1:0]];

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } ret_t;
  ret_t rq[$];

  int            m_last;
  int            m_rr;
  logic          e_strobe;
  logic [N-1:0]  e_ack;
  logic          e_write;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wrdata;
  logic [N-1:0]  e_rdv;
  logic [DW-1:0] e_rd_data;
  logic [N-1:0]  last_ack;

  logic          hist_s [8];
  logic [AW-1:0] hist_a [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[17:10];
  endfunction

  task automatic model_reset();
    m_last    = -1;
    m_rr      = int'(N) - 1;
    e_addr    = '0;
    e_wrdata  = '0;
    e_rd_data = '0;
    last_ack  = '0;
    rq.delete();
    for (int i = 0; i < 8; i++) begin
      hist_s[i] = 1'b0;
      hist_a[i] = '0;
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_strobe"}, 32'(bus.intbus_strobe), 32'd0);
    check_eq({tag, "_ack"},    32'(bus.req_ack),       32'd0);
    check_eq({tag, "_write"},  32'(bus.intbus_write),  32'd0);
    check_eq({tag, "_addr"},   32'(bus.intbus_addr),   32'd0);
    check_eq({tag, "_wrdata"}, 32'(bus.intbus_wrdata), 32'd0);
    check_eq({tag, "_rdv"},    32'(bus.rd_valid),      32'd0);
    check_eq({tag, "_rdata"},  32'(bus.rd_data),       32'd0);
  endtask

  task automatic drive_inputs();
    bus.req_valid = drv_valid;
    bus.req_write = drv_wr;
    for (int i = 0; i < int'(N); i++) begin
      bus.req_addr[i*AW +: AW]   = drv_addr[i];
      bus.req_wrdata[i*DW +: DW] = drv_data[i];
    end
  endtask

  // One clock: predict the grant from the arbitration rules, then compare after the edge.
  task automatic tick();
    int  g;
    bit  prio_win;
    drive_inputs();
    g        = -1;
    prio_win = 1'b0;
`ifdef INTBUS_ARB_PRIO0_EN
    if (drv_valid[0] && m_last != 0) begin
      g        = 0;
      prio_win = 1'b1;
    end
`endif
    if (g < 0) begin
      for (int k = 1; k <= int'(N); k++) begin
        int cand;
        cand = (m_rr + k) % int'(N);
        if (drv_valid[cand] && cand != m_last) begin
          g = cand;
          break;
        end
      end
    end
    e_strobe = (g >= 0);
    e_ack    = '0;
    e_write  = 1'b0;
    if (g >= 0) begin
      e_ack[g] = 1'b1;
      e_write  = drv_wr[g];
      e_addr   = drv_addr[g];
      e_wrdata = drv_data[g];
      if (!prio_win) m_rr = g;
      if (!drv_wr[g]) rq.push_back('{due: cyc + int'(L) + 2, id: g, data: mem_rd(drv_addr[g])});
    end
    m_last = g;

    @(posedge clk);
    cyc++;
    #1;
    hist_s[cyc % 8] = bus.intbus_strobe & ~bus.intbus_write;
    hist_a[cyc % 8] = bus.intbus_addr;
    if (cyc >= int'(L) && hist_s[(cyc - int'(L)) % 8])
      bus.intbus_rddata = mem_rd(hist_a[(cyc - int'(L)) % 8]);
    else
      bus.intbus_rddata = DW'($urandom);

    e_rdv = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rdv[rq[0].id] = 1'b1;
      e_rd_data       = rq[0].data;
      rq.delete(0);
    end
    check_eq("strobe", 32'(bus.intbus_strobe), 32'(e_strobe));
    check_eq("ack",    32'(bus.req_ack),       32'(e_ack));
    check_eq("write",  32'(bus.intbus_write),  32'(e_write));
    check_eq("addr",   32'(bus.intbus_addr),   32'(e_addr));
    check_eq("wrdata", 32'(bus.intbus_wrdata), 32'(e_wrdata));
    check_eq("rd_valid", 32'(bus.rd_valid),    32'(e_rdv));
    check_eq("rd_data",  32'(bus.rd_data),     32'(e_rd_data));
    last_ack = e_ack;
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    res_n = 1'b0;
    #1;
    check_idle({tag, "_async"});
    model_reset();
    @(posedge clk);
    #1;
    check_idle({tag, "_hold"});
    @(negedge clk);
    res_n = 1'b1;
  endtask

  task automatic new_fields(input int i);
    drv_addr[i] = AW'($urandom);
    drv_wr[i]   = 1'($urandom);
    drv_data[i] = DW'($urandom);
  endtask

  int seq2 [9];

  initial begin
    drv_valid = '0;
    drv_wr    = '0;
    for (int i = 0; i < int'(N); i++) begin
      drv_addr[i] = '0;
      drv_data[i] = '0;
    end
    drive_inputs();
    bus.intbus_rddata = '0;
    model_reset();
    mem[18'h1F9C0] = 8'hA5;
    mem[18'h000A2] = 8'h11;
    mem[18'h000A0] = 8'h22;

    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    res_n = 1'b1;

    // Single read from requester 0 and its return three edges later.
    drv_valid = 3'b001; drv_wr = '0; drv_addr[0] = 18'h1F9C0;
    tick();
    check_eq("t1_strobe", 32'(bus.intbus_strobe), 32'd1);
    check_eq("t1_ack",    32'(bus.req_ack),       32'b001);
    check_eq("t1_addr",   32'(bus.intbus_addr),   32'h1F9C0);
    check_eq("t1_write",  32'(bus.intbus_write),  32'd0);
    drv_valid = '0;
    tick();
    tick();
    check_eq("t1_early_rdv", 32'(bus.rd_valid), 32'd0);
    tick();
    check_eq("t1_rdv",   32'(bus.rd_valid), 32'b001);
    check_eq("t1_rdata", 32'(bus.rd_data),  32'hA5);

    // All three held: rotation (or priority-0 interleave) from a fresh pointer.
    pulse_reset("t2_rst");
`ifdef INTBUS_ARB_PRIO0_EN
    seq2 = '{0, 1, 0, 2, 0, 1, 0, 2, 0};
`else
    seq2 = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
`endif
    drv_valid = 3'b111; drv_wr = '0;
    for (int i = 0; i < int'(N); i++) drv_addr[i] = AW'(32'h100 + i);
    for (int k = 0; k < 9; k++) begin
      tick();
      check_eq($sformatf("t2_ack%0d", k), 32'(bus.req_ack), 32'(1) << seq2[k]);
    end
    drv_valid = '0;
    repeat (4) tick();

    // Lone continuous writer gets every other cycle.
    drv_valid = 3'b010; drv_wr = 3'b010; drv_data[1] = 8'h3C; drv_addr[1] = 18'h2ABCD;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq($sformatf("t3_ack%0d", k), 32'(bus.req_ack), (k % 2 == 0) ? 32'b010 : 32'd0);
      if (k % 2 == 0) begin
        check_eq("t3_write",  32'(bus.intbus_write),  32'd1);
        check_eq("t3_wrdata", 32'(bus.intbus_wrdata), 32'h3C);
      end
      check_eq("t3_rdv", 32'(bus.rd_valid), 32'd0);
    end
    drv_valid = '0; drv_wr = '0;
    repeat (4) tick();

    // Back-to-back reads from different requesters return in order.
    drv_valid = 3'b100; drv_addr[2] = 18'h000A2;
    tick();
    check_eq("t4_ack2", 32'(bus.req_ack), 32'b100);
    drv_valid = 3'b001; drv_addr[0] = 18'h000A0;
    tick();
    check_eq("t4_ack0", 32'(bus.req_ack), 32'b001);
    drv_valid = '0;
    tick();
    tick();
    check_eq("t4_rdv2",   32'(bus.rd_valid), 32'b100);
    check_eq("t4_rdata2", 32'(bus.rd_data),  32'h11);
    tick();
    check_eq("t4_rdv0",   32'(bus.rd_valid), 32'b001);
    check_eq("t4_rdata0", 32'(bus.rd_data),  32'h22);

    // Reset right after a read strobe discards the read and restarts at requester 0.
    drv_valid = 3'b001; drv_addr[0] = 18'h12345;
    tick();
    check_eq("t5_strobe", 32'(bus.intbus_strobe), 32'd1);
    drv_valid = '0;
    pulse_reset("t5_rst");
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("t5_no_rdv", 32'(bus.rd_valid), 32'd0);
    end
    drv_valid = 3'b111;
    tick();
    check_eq("t5_first_ack", 32'(bus.req_ack), 32'b001);
    drv_valid = '0;
    repeat (4) tick();

    // Randomized requesters: hold until ack, occasional withdraw or field change.
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (last_ack[i]) begin
          drv_valid[i] = 1'($urandom_range(0, 1));
          new_fields(i);
        end else if (drv_valid[i]) begin
          if ($urandom_range(0, 15) == 0) drv_valid[i] = 1'b0;
          else if ($urandom_range(0, 7) == 0) new_fields(i);
        end else if ($urandom_range(0, 2) == 0) begin
          drv_valid[i] = 1'b1;
          new_fields(i);
        end
      end
      if (t % 500 == 250) pulse_reset("rand_rst");
      tick();
    end
    drv_valid = '0;
    repeat (6) tick();
    check_eq("drain_empty", 32'(rq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
